mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - EX/MEM + MEM/WB pipeline slice of the LEGv8 pipeline, directly downstream of execute.
// - Registers execute results (PCBranch_E, aluResult_E, writeData_E, zero_E) plus control into the M slot.
// - Runs a req/ack data-memory transaction and stalls upstream until ack.
// - Resolves the branch (PCSrc_M) and registers results into the W slot for writeback.
// PARAMETERS
// - N               64   datapath width (address, data, PC)
// - TIMEOUT_CYCLES  255  max WAIT cycles before abort (only with MEM_TIMEOUT_EN)
// PORTS
// - clk          in   1   clock, rising edge
// - reset        in   1   asynchronous, active-low reset
// - valid_E      in   1   E slot holds a real instruction
// - flush_E      in   1   turn the E instruction into a bubble on capture
// - PCBranch_E   in   N   branch target from execute
// - aluResult_E  in   N   ALU result / memory address
// - writeData_E  in   N   store data
// - zero_E       in   1   ALU zero flag
// - memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E  in  1 each  control bits
// - writeReg_E   in   5   destination register
// - stall_M      out  1   hold E and earlier stages this cycle
// - PCSrc_M      out  1   branch taken = valid_M & branch_M & zero_M
// - PCBranch_M   out  N   registered branch target
// - dm_req       out  1   memory request
// - dm_we        out  1   1 = store, 0 = load
// - dm_addr      out  N   aluResult_M
// - dm_wdata     out  N   writeData_M
// - dm_ack       in   1   one-cycle completion pulse
// - dm_rdata     in   N   load data, valid when dm_ack=1
// - valid_W, regWrite_W, memtoReg_W  out  1 each
// - readData_W   out  N   registered load data
// - aluResult_W  out  N   registered ALU result
// - writeReg_W   out  5   registered destination
// - mem_error    out  1   sticky timeout flag (tied 0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
// - Reset (async, reset=0): every M/W register, every output and the timeout counter go to 0; FSM -> IDLE.
// - Reset mid-access: dm_req drops immediately and the pending access is abandoned.
// - FSM IDLE: dm_req=0.
// - FSM WAIT: dm_req=1 while the M slot holds a valid memRead or memWrite not yet acked.
// - advance = ~stall_M; stall_M = dm_req & ~dm_ack (combinational).
// - Zero-wait ack, i.e. ack in the first WAIT cycle, gives no stall.
// - On advance, M captures the E inputs. If flush_E=1 or valid_E=0, valid_M=0 and all M control bits are cleared.
// - Next state after advance: WAIT if the captured instruction is a valid memory op, else IDLE.
//   - This holds from WAIT too: ack and a new capture happen in the same cycle.
// - While stalled, M holds its contents; flush_E is ignored because the E instruction is not consumed.
// - dm_addr, dm_we and dm_wdata stay stable while dm_req=1. dm_ack while dm_req=0 is ignored.
// - W capture on advance: W <= M. readData_W <= dm_rdata if the op was a load, else 0.
// - W capture while stalled: bubble (valid_W=0, regWrite_W=0, memtoReg_W=0).
// - Stores never write back; regWrite_W comes from the control bits as given.
// - Latency: non-memory op, E->W 2 cycles. Memory op, 2 + (cycles until dm_ack) cycles.
// - PCSrc_M is combinational from M registers. A bubble never takes a branch.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - Counter counts WAIT cycles and resets on every entry to WAIT.
//   - At TIMEOUT_CYCLES with no ack: force advance and drop dm_req.
//   - Deliver a bubble to W (valid_W=0) and set mem_error=1 until reset.
// - MEM_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; mem_error=0.
// TESTING
// - Reset while in WAIT -> dm_req=0 at once; all W outputs 0; after release, FSM in IDLE.
// - ADD, aluResult_E=0x10, regWrite_E=1, writeReg_E=3 -> 2 cycles later: valid_W=1, aluResult_W=0x10, writeReg_W=3, no stall.
// - LDUR addr 0x20, dm_ack 3 cycles after dm_req rises:
//   - stall_M=1 for 3 cycles, W bubbles meanwhile.
//   - Then readData_W=dm_rdata (0xDEADBEEF), memtoReg_W=1.
// - Store with zero-wait ack -> dm_we=1, dm_wdata=writeData_E, stall_M never asserted.
// - CBZ, branch_E=1, zero_E=1, PCBranch_E=0x400 -> next cycle PCSrc_M=1, PCBranch_M=0x400.
//   - Same with flush_E=1 -> PCSrc_M=0.
// - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stall released after 4 cycles, valid_W=0, mem_error=1 held.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and
// the data memory (or its arbiter).
//
// Ports / signals:
//   dm_req    stage -> mem   request active; address/data/we held stable while high
//   dm_we     stage -> mem   1 = store, 0 = load
//   dm_addr   stage -> mem   byte address (N bits)
//   dm_wdata  stage -> mem   store data (N bits)
//   dm_ack    mem -> stage   one-cycle completion pulse
//   dm_rdata  mem -> stage   load data, valid while dm_ack=1
//
// Modports: master = pipeline stage, slave = memory.
interface mem_access_stage_if #(
    parameter int N = 64
);
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// EX/MEM + MEM/WB slice of the LEGv8 pipeline, directly downstream of execute.
// Captures execute results into the M slot, runs a req/ack data-memory access,
// stalls upstream until the access completes, resolves the branch and
// registers results into the W slot for writeback.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   *_E inputs           execute-stage results, control bits and valid/flush
//   stall_M              hold E and earlier stages this cycle
//   PCSrc_M, PCBranch_M  branch decision and registered target
//   dm (master)          data-memory bus, see mem_access_stage_if
//   *_W outputs          writeback slot
//   mem_error            sticky access-timeout flag
//
// Build option: define MEM_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES cycles without dm_ack. Without it, the stage waits forever
// and mem_error is tied to 0.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | M slot holds no pending memory op, dm_req=0
// WAIT  | M slot holds a valid load/store not yet acknowledged, dm_req=1
module mem_access_stage #(
    parameter int N              = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      valid_E,
    input  logic                      flush_E,
    input  logic [N-1:0]              PCBranch_E,
    input  logic [N-1:0]              aluResult_E,
    input  logic [N-1:0]              writeData_E,
    input  logic                      zero_E,
    input  logic                      memRead_E,
    input  logic                      memWrite_E,
    input  logic                      branch_E,
    input  logic                      regWrite_E,
    input  logic                      memtoReg_E,
    input  logic [4:0]                writeReg_E,

    output logic                      stall_M,
    output logic                      PCSrc_M,
    output logic [N-1:0]              PCBranch_M,

    mem_access_stage_if.master        dm,

    output logic                      valid_W,
    output logic                      regWrite_W,
    output logic                      memtoReg_W,
    output logic [N-1:0]              readData_W,
    output logic [N-1:0]              aluResult_W,
    output logic [4:0]                writeReg_W,
    output logic                      mem_error
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT_CYCLES must be at least 1");
    end

    logic [0:0]   state;

    logic         valid_M;
    logic         zero_M;
    logic         memRead_M;
    logic         memWrite_M;
    logic         branch_M;
    logic         regWrite_M;
    logic         memtoReg_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic [4:0]   writeReg_M;

    logic         in_wait;
    logic         timeout_hit;
    logic         advance;
    logic         capture_valid;
    logic         capture_mem;

    assign in_wait = (state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt is 0 in the first WAIT cycle, so the request is stalled for
    // exactly TIMEOUT_CYCLES cycles before the forced advance.
    assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            if (advance)
                wait_cnt <= '0;
            else if (in_wait)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                mem_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    // The request is a pure decode of the state register, so an async reset
    // removes it in the same instant.
    assign dm.dm_req   = in_wait & ~timeout_hit;
    assign dm.dm_we    = memWrite_M;
    assign dm.dm_addr  = aluResult_M;
    assign dm.dm_wdata = writeData_M;

    assign stall_M = dm.dm_req & ~dm.dm_ack;
    assign advance = ~stall_M;

    assign PCSrc_M = valid_M & branch_M & zero_M;

    assign capture_valid = valid_E & ~flush_E;
    assign capture_mem   = capture_valid & (memRead_E | memWrite_E);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            valid_M     <= 1'b0;
            zero_M      <= 1'b0;
            memRead_M   <= 1'b0;
            memWrite_M  <= 1'b0;
            branch_M    <= 1'b0;
            regWrite_M  <= 1'b0;
            memtoReg_M  <= 1'b0;
            PCBranch_M  <= '0;
            aluResult_M <= '0;
            writeData_M <= '0;
            writeReg_M  <= '0;
        end else if (advance) begin
            state       <= capture_mem ? S_WAIT : S_IDLE;
            valid_M     <= capture_valid;
            zero_M      <= zero_E;
            memRead_M   <= capture_valid & memRead_E;
            memWrite_M  <= capture_valid & memWrite_E;
            branch_M    <= capture_valid & branch_E;
            regWrite_M  <= capture_valid & regWrite_E;
            memtoReg_M  <= capture_valid & memtoReg_E;
            PCBranch_M  <= PCBranch_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            writeReg_M  <= writeReg_E;
        end
    end

    // A timed-out access reaches W as a bubble so nothing is written back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_W     <= 1'b0;
            regWrite_W  <= 1'b0;
            memtoReg_W  <= 1'b0;
            readData_W  <= '0;
            aluResult_W <= '0;
            writeReg_W  <= '0;
        end else if (advance) begin
            valid_W     <= valid_M & ~timeout_hit;
            regWrite_W  <= regWrite_M & ~timeout_hit;
            memtoReg_W  <= memtoReg_M & ~timeout_hit;
            readData_W  <= (memRead_M & ~timeout_hit) ? dm.dm_rdata : '0;
            aluResult_W <= aluResult_M;
            writeReg_W  <= writeReg_M;
        end else begin
            valid_W     <= 1'b0;
            regWrite_W  <= 1'b0;
            memtoReg_W  <= 1'b0;
        end
    end

endmodule
